// File: rtl/zpred_seq.sv
// zpred_seq: G.726 sixth-order zero predictor. It holds the DQ1..DQ6 float delay line and forms SEZ serially with one shared FMULT.
// Build option ZPRED_SEZI_EN adds the registered full-precision sum output SEZI.
module zpred_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    input  logic        start,
    input  logic        dq_load,
    input  logic [10:0] DQ0,
    input  logic [95:0] B,
    output logic [14:0] SEZ,
`ifdef ZPRED_SEZI_EN
    output logic [15:0] SEZI,
`endif
    output logic        busy,
    output logic        done,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4
);

    localparam int NTAP  = 6;
    localparam int CNT_W = 3;
    localparam logic [10:0] DQ_INIT = 11'h020;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic signed [15:0]       acc_q, acc_d;
    logic [NTAP-1:0][15:0]    b_q, b_d;
    logic [NTAP-1:0][10:0]    dq_q, dq_d;
    logic [10:0]              dqc_q, dqc_d;
    logic                     pend_q, pend_d;
    logic [14:0]              sez_q, sez_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic signed [15:0]       wb;
`ifdef ZPRED_SEZI_EN
    logic [15:0]              sezi_q, sezi_d;
`endif

    // Floating multiply of one predictor coefficient by one delay-line sample.
    function automatic logic signed [15:0] fmult(input logic [15:0] bn, input logic [10:0] dqn);
        logic        an_s;
        logic [15:0] an_abs;
        logic [12:0] an_mag;
        logic [3:0]  an_exp;
        logic [18:0] an_norm;
        logic [5:0]  an_mant;
        logic        ws;
        logic [4:0]  wexp;
        logic [11:0] prod;
        logic [7:0]  wmant;
        logic [31:0] wext;
        logic [15:0] wmag;
        an_s   = bn[15];
        an_abs = an_s ? (16'd0 - bn) : bn;
        an_mag = an_abs[14:2];
        an_exp = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (an_mag[i]) an_exp = 4'(i + 1);
        end
        an_norm = {an_mag, 6'b0} >> an_exp;
        an_mant = (an_mag == 13'd0) ? 6'd32 : an_norm[5:0];
        ws      = an_s ^ dqn[10];
        wexp    = {1'b0, dqn[9:6]} + {1'b0, an_exp};
        prod    = {6'b0, dqn[5:0]} * {6'b0, an_mant} + 12'd48;
        wmant   = prod[11:4];
        wext    = {17'b0, wmant, 7'b0};
        if (wexp > 5'd26) wext = wext << (wexp - 5'd26);
        else              wext = wext >> (5'd26 - wexp);
        wmag    = {1'b0, wext[14:0]};
        return ws ? $signed(16'd0 - wmag) : $signed(wmag);
    endfunction

    assign wb = fmult(b_q[idx_q], dq_q[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        b_d     = b_q;
        dq_d    = dq_q;
        dqc_d   = dqc_q;
        pend_d  = pend_q;
        sez_d   = sez_q;
        busy_d  = (state_q != S_IDLE);
        done_d  = (state_q == S_DONE);
`ifdef ZPRED_SEZI_EN
        sezi_d  = sezi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dq_load) dq_d = {dq_q[NTAP-2:0], DQ0};
                if (start) begin
                    b_d     = B;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                // A load arriving mid-computation must not disturb the taps still to be read.
                if (dq_load) begin
                    pend_d = 1'b1;
                    dqc_d  = DQ0;
                end
                acc_d = acc_q + wb;
                idx_d = idx_q + 1'b1;
                if (idx_q == CNT_W'(NTAP - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                sez_d = acc_q[15:1];
`ifdef ZPRED_SEZI_EN
                sezi_d = acc_q;
`endif
                if (dq_load)     dq_d = {dq_q[NTAP-2:0], DQ0};
                else if (pend_q) dq_d = {dq_q[NTAP-2:0], dqc_q};
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            dq_q    <= {NTAP{DQ_INIT}};
            pend_q  <= 1'b0;
            sez_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ZPRED_SEZI_EN
            sezi_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            dq_q    <= dq_d;
            pend_q  <= pend_d;
            sez_q   <= sez_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ZPRED_SEZI_EN
            sezi_q  <= sezi_d;
`endif
        end
    end

    // Latched operands are only read after being loaded, so they need no reset.
    always_ff @(posedge clk) begin
        b_q   <= b_d;
        dqc_q <= dqc_d;
    end

    assign SEZ  = sez_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef ZPRED_SEZI_EN
    assign SEZI = sezi_q;
`endif

    // Scan chains are stitched at DFT insertion; until then they pass through only in shift mode.
    assign scan_out0 = test_mode & scan_enable & scan_in0;
    assign scan_out1 = test_mode & scan_enable & scan_in1;
    assign scan_out2 = test_mode & scan_enable & scan_in2;
    assign scan_out3 = test_mode & scan_enable & scan_in3;
    assign scan_out4 = test_mode & scan_enable & scan_in4;

endmodule

// File: tb/tb_zpred_seq.sv
// tb_zpred_seq: directed table, hand-written corner sequences and randomized transactions for zpred_seq.
// The expected results come from a transaction-level reference of the zero predictor.
module tb_zpred_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic        scan_enable, test_mode;
    logic        start, dq_load;
    logic [10:0] DQ0;
    logic [95:0] B;
    logic [14:0] SEZ;
    logic        busy, done;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
`ifdef ZPRED_SEZI_EN
    logic [15:0] SEZI;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int mdq[$];

    always #5 clk = ~clk;

    zpred_seq dut (
        .clk(clk), .reset(reset),
        .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
        .scan_in3(scan_in3), .scan_in4(scan_in4),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .start(start), .dq_load(dq_load), .DQ0(DQ0), .B(B),
        .SEZ(SEZ),
`ifdef ZPRED_SEZI_EN
        .SEZI(SEZI),
`endif
        .busy(busy), .done(done),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4)
    );

    typedef struct {
        logic [95:0] b;
        logic        ld;
        logic [10:0] d0;
        logic [14:0] sez;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
`ifdef ERRORSTOP
            $fatal(1, "stopping at first miscompare");
`endif
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference FMULT from the number format rules, in plain integer arithmetic.
    function automatic int fmult_ref(input logic [15:0] bs, input logic [10:0] dq);
        int bn, mag, aexp, amant, wexp, wmant, wmag;
        bit neg_w;
        bn    = {{16{bs[15]}}, bs};
        mag   = ((bn < 0) ? -bn : bn) / 4;
        mag   = mag % 8192;
        aexp  = 0;
        while ((1 << aexp) <= mag) aexp++;
        amant = (mag == 0) ? 32 : (mag * 64) / (1 << aexp);
        neg_w = (bn < 0) != (dq[10] == 1'b1);
        wexp  = int'(dq[9:6]) + aexp;
        wmant = (int'(dq[5:0]) * amant + 48) / 16;
        if (wexp > 26) wmag = (wmant * 128) * (1 << (wexp - 26));
        else           wmag = (wmant * 128) / (1 << (26 - wexp));
        wmag  = wmag % 32768;
        return neg_w ? -wmag : wmag;
    endfunction

    function automatic int sum_ref(input logic [95:0] b);
        int s;
        s = 0;
        for (int n = 0; n < 6; n++) s += fmult_ref(b[16*n +: 16], 11'(mdq[n]));
        return s & 32'hFFFF;
    endfunction

    function automatic void mshift(input logic [10:0] d);
        mdq.push_front(int'(d));
        void'(mdq.pop_back());
    endfunction

    function automatic logic [95:0] rand_b();
        logic [95:0] r;
        logic [15:0] v;
        for (int n = 0; n < 6; n++) begin
            v = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) v = 16'd0 - v;
            r[16*n +: 16] = v;
        end
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; dq_load = 1'b0; DQ0 = '0; B = '0;
        cyc();
        reset = 1'b1;
        mdq = '{32, 32, 32, 32, 32, 32};
    endtask

    // One start with optional load in the same cycle, then six MAC cycles with optional
    // loads/starts; B is scrambled during MAC to show the latched copy is used.
    task automatic run_txn(input string tag, input logic [95:0] b, input logic ld,
                           input logic [10:0] d0, input logic [5:0] lmask,
                           input logic [5:0][10:0] ld0, input logic [5:0] smask,
                           input logic [14:0] exp_sez, input logic [15:0] exp_sezi);
        int lat, nbusy, ndone;
        logic [14:0] sez_c;
        logic [15:0] sezi_c;
        B = b; start = 1'b1; dq_load = ld; DQ0 = d0;
        cyc();
        lat = -1; nbusy = 0; ndone = 0; sez_c = '0; sezi_c = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 6) begin
                B = ~b; dq_load = lmask[k-1]; DQ0 = ld0[k-1]; start = smask[k-1];
            end else begin
                B = b; dq_load = 1'b0; start = 1'b0;
            end
            cyc();
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    sez_c = SEZ;
`ifdef ZPRED_SEZI_EN
                    sezi_c = SEZI;
`endif
                end
            end
        end
        chk({tag, ".latency"}, lat, 7);
        chk({tag, ".busy_cycles"}, nbusy, 7);
        chk({tag, ".done_pulses"}, ndone, 1);
        chk({tag, ".sez"}, {17'b0, sez_c}, {17'b0, exp_sez});
        chk({tag, ".sez_held"}, {17'b0, SEZ}, {17'b0, exp_sez});
`ifdef ZPRED_SEZI_EN
        chk({tag, ".sezi"}, {16'b0, sezi_c}, {16'b0, exp_sezi});
`else
        if (sezi_c != exp_sezi) begin end
`endif
    endtask

    initial begin
        logic [5:0][10:0] ld0;
        logic [95:0] rb;
        logic        rld;
        logic [10:0] rd0;
        logic [5:0]  rlm, rsm;
        int          s;

        scan_in0 = 0; scan_in1 = 0; scan_in2 = 0; scan_in3 = 0; scan_in4 = 0;
        scan_enable = 0; test_mode = 0;
        reset = 1'b0; start = 1'b0; dq_load = 1'b0; DQ0 = '0; B = '0;
        ld0 = '0;

        tbl[0] = '{96'h0,                          1'b0, 11'h000, 15'h0000};
        tbl[1] = '{96'h4000,                       1'b1, 11'h260, 15'h010C};
        tbl[2] = '{96'hC000,                       1'b1, 11'h260, 15'h7EF4};
        tbl[3] = '{96'h4000_4000_4000_4000_4000_4000, 1'b0, 11'h000, 15'h0003};
        tbl[4] = '{96'h4000,                       1'b1, 11'h660, 15'h7EF4};
        tbl[5] = '{96'h4000,                       1'b1, 11'h3E0, 15'h0300};
        tbl[6] = '{96'h0004,                       1'b1, 11'h3E0, 15'h0004};
        tbl[7] = '{96'h7FFF,                       1'b1, 11'h3E0, 15'h0100};
        tbl[8] = '{96'h8000,                       1'b1, 11'h260, 15'h0000};

        cyc(); cyc();
        chk("reset.busy", {31'b0, busy}, 0);
        chk("reset.done", {31'b0, done}, 0);
        chk("reset.sez",  {17'b0, SEZ},  0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (tbl[i].ld) mshift(tbl[i].d0);
            s = sum_ref(tbl[i].b);
            run_txn($sformatf("tbl%0d", i), tbl[i].b, tbl[i].ld, tbl[i].d0, 6'b0, ld0, 6'b0,
                    tbl[i].sez, 16'(s));
        end

        // Load during MAC is deferred to DONE and does not touch the running result.
        do_reset();
        ld0 = '0; ld0[1] = 11'h260;
        run_txn("defer1", 96'h4000, 1'b0, 11'h0, 6'b000010, ld0, 6'b0, 15'h0000, 16'h0001);
        run_txn("defer2", 96'h4000, 1'b0, 11'h0, 6'b0, ld0, 6'b0, 15'h010C, 16'h0218);

        // Two loads during one MAC: only the last one shifts in, once.
        do_reset();
        ld0 = '0; ld0[1] = 11'h111; ld0[3] = 11'h260;
        run_txn("dbl1", 96'h4000_4000, 1'b0, 11'h0, 6'b001010, ld0, 6'b0, 15'h0001, 16'h0002);
        run_txn("dbl2", 96'h4000_4000, 1'b0, 11'h0, 6'b0, ld0, 6'b0, 15'h010C, 16'h0219);

        // Starts during MAC are ignored.
        do_reset();
        ld0 = '0;
        run_txn("restart", 96'h4000, 1'b1, 11'h260, 6'b0, ld0, 6'b111111, 15'h010C, 16'h0218);

        // Reset in the middle of MAC returns everything, including the delay line, to reset values.
        B = 96'h0; start = 1'b1; cyc();
        start = 1'b0; cyc(); cyc();
        reset = 1'b0; cyc();
        reset = 1'b1;
        chk("midrst.busy", {31'b0, busy}, 0);
        chk("midrst.done", {31'b0, done}, 0);
        chk("midrst.sez",  {17'b0, SEZ},  0);
        mdq = '{32, 32, 32, 32, 32, 32};
        run_txn("midrst.zero", 96'h0, 1'b0, 11'h0, 6'b0, ld0, 6'b0, 15'h0000, 16'h0000);
        run_txn("midrst.dq", 96'h4000_4000_4000_4000_4000_4000, 1'b0, 11'h0, 6'b0, ld0, 6'b0,
                15'h0003, 16'h0006);

        // Randomized transactions against the reference.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                dq_load = ($urandom_range(0, 1) == 1);
                DQ0 = 11'($urandom);
                cyc();
                if (dq_load) mshift(DQ0);
                dq_load = 1'b0;
            end
            rb  = rand_b();
            rld = ($urandom_range(0, 2) == 0);
            rd0 = 11'($urandom);
            rlm = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'b0;
            rsm = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            for (int k = 0; k < 6; k++) ld0[k] = 11'($urandom);
            if (rld) mshift(rd0);
            s = sum_ref(rb);
            run_txn($sformatf("rnd%0d", t), rb, rld, rd0, rlm, ld0, rsm, 15'(s >> 1), 16'(s));
            for (int k = 5; k >= 0; k--) begin
                if (rlm[k]) begin
                    mshift(ld0[k]);
                    break;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
